// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared pipeline package for the writeback / register-file slice.
//   WORD_W    : default data word width
//   REG_AW    : default register address width (2**REG_AW registers)
//   NOP_INSTR : encoding of a pipeline bubble in the writeback stage
//   isBubble  : helper that recognises a bubble instruction
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

   localparam int          WORD_W    = 32;
   localparam int          REG_AW    = 5;
   localparam logic [31:0] NOP_INSTR = 32'h0;

   function automatic logic isBubble(input logic [31:0] instr);
      return (instr == NOP_INSTR);
   endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// ---------------------------------------------------------------------------
// wb_regfile_array
// Register storage with one synchronous write port and two raw
// combinational read ports. Reads return the stored contents only; the
// zero-register and bypass rules are applied by the parent.
// Ports:
//   clock, reset_n          : rising-edge clock, async active-low clear
//   writeEn/Addr/Data       : write port, takes effect on the clock edge
//   readAddrA/readDataA     : raw read port A
//   readAddrB/readDataB     : raw read port B
// ---------------------------------------------------------------------------
module wb_regfile_array
#(
   parameter int WORD_W = wb_regfile_pkg::WORD_W,
   parameter int REG_AW = wb_regfile_pkg::REG_AW
)
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              writeEn,
   input  logic [REG_AW-1:0] writeAddr,
   input  logic [WORD_W-1:0] writeData,
   input  logic [REG_AW-1:0] readAddrA,
   output logic [WORD_W-1:0] readDataA,
   input  logic [REG_AW-1:0] readAddrB,
   output logic [WORD_W-1:0] readDataB
);

   localparam int NUM_REGS = 2 ** REG_AW;

   logic [WORD_W-1:0] regs [NUM_REGS];

   // Register 0 is cleared on reset like every other entry and is never
   // written afterwards, so a raw read of it always yields zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         regs <= '{default: '0};
      end else if (writeEn && (writeAddr != '0)) begin
         regs[writeAddr] <= writeData;
      end
   end

   assign readDataA = regs[readAddrA];
   assign readDataB = regs[readAddrB];

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus register file. Selects the writeback value, commits
// it to the array, forwards it to the decode read ports in the same cycle
// (write-before-read) and counts retired non-bubble instructions.
// Ports:
//   clock, reset_n             : rising-edge clock, async active-low reset
//   enable                     : writeback-stage enable, gates all updates
//   iInstr                     : instruction in writeback (0 = bubble)
//   iRegWrite, iMemToReg       : writeback controls
//   iouputData, iALUResult     : memory read data / ALU result
//   iwriteRegWire              : destination register
//   rs_addr, rt_addr           : decode read addresses
//   rs_data, rt_data           : decode read data (bypassed)
//   wb_data                    : selected writeback value
//   wb_we                      : register write commits this cycle
//   retire_count               : retired non-bubble instruction count
// ---------------------------------------------------------------------------
module wb_regfile
#(
   parameter int WORD_W = wb_regfile_pkg::WORD_W,
   parameter int REG_AW = wb_regfile_pkg::REG_AW
)
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [31:0]       iInstr,
   input  logic              iRegWrite,
   input  logic              iMemToReg,
   input  logic [WORD_W-1:0] iouputData,
   input  logic [WORD_W-1:0] iALUResult,
   input  logic [REG_AW-1:0] iwriteRegWire,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   output logic [WORD_W-1:0] rs_data,
   output logic [WORD_W-1:0] rt_data,
   output logic [WORD_W-1:0] wb_data,
   output logic              wb_we,
   output logic [31:0]       retire_count
);

   import wb_regfile_pkg::*;

   logic [WORD_W-1:0] arrRsData;
   logic [WORD_W-1:0] arrRtData;
   logic [31:0]       retireCount;

   // A known-0 select picks the ALU result cleanly, so an unknown load
   // value cannot leak into the array on ALU writebacks.
   assign wb_data = iMemToReg ? iouputData : iALUResult;

   // Writes to register 0 are dropped here, which also keeps them out of
   // the bypass path. Reset deliberately does not gate this term.
   assign wb_we = enable & iRegWrite & (iwriteRegWire != '0);

   wb_regfile_array #(
      .WORD_W (WORD_W),
      .REG_AW (REG_AW)
   ) u_array (
      .clock     (clock),
      .reset_n   (reset_n),
      .writeEn   (wb_we),
      .writeAddr (iwriteRegWire),
      .writeData (wb_data),
      .readAddrA (rs_addr),
      .readDataA (arrRsData),
      .readAddrB (rt_addr),
      .readDataB (arrRtData)
   );

   // Each port bypasses independently when it reads the register being
   // written this cycle.
   always_comb begin
      rs_data = arrRsData;
      if (rs_addr == '0) begin
         rs_data = '0;
      end else if (wb_we && (rs_addr == iwriteRegWire)) begin
         rs_data = wb_data;
      end
   end

   always_comb begin
      rt_data = arrRtData;
      if (rt_addr == '0) begin
         rt_data = '0;
      end else if (wb_we && (rt_addr == iwriteRegWire)) begin
         rt_data = wb_data;
      end
   end

   // Counts every non-bubble instruction leaving writeback, whether or not
   // it writes a register; wraps silently.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retireCount <= '0;
      end else if (enable && !isBubble(iInstr)) begin
         retireCount <= retireCount + 32'd1;
      end
   end

   assign retire_count = retireCount;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning the register address width (2^REG_AW registers).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port enable, input, 1, the writeback-stage enable gating all state updates.
REQ-006 The block SHALL have port iInstr, input, 32, the instruction in writeback (32'h0 = bubble).
REQ-007 The block SHALL have ports iRegWrite and iMemToReg, input, 1 each, the writeback controls.
REQ-008 The block SHALL have ports iouputData and iALUResult, input, WORD_W each, carrying memory read data and the ALU result.
REQ-009 The block SHALL have port iwriteRegWire, input, REG_AW, the destination register.
REQ-010 The block SHALL have ports rs_addr and rt_addr, input, REG_AW each, the decode-stage read addresses.
REQ-011 The block SHALL have ports rs_data and rt_data, output, WORD_W each, the read data.
REQ-012 The block SHALL have port wb_data, output, WORD_W, the selected writeback value for forwarding.
REQ-013 The block SHALL have port wb_we, output, 1, high when a register write commits this cycle.
REQ-014 The block SHALL have port retire_count, output, 32, the count of retired non-bubble instructions.

Function
REQ-015 wb_data SHALL be combinational: iouputData when iMemToReg=1, else iALUResult.
REQ-016 wb_we SHALL equal enable AND iRegWrite AND (iwriteRegWire != 0), combinationally.
REQ-017 On the rising edge with wb_we=1, register[iwriteRegWire] SHALL load wb_data; latency to array is one edge.
REQ-018 Register 0 SHALL never be written and SHALL always read 0.
REQ-019 rs_data/rt_data SHALL be combinational reads; an address of 0 SHALL return 0.
REQ-020 Bypass: when wb_we=1 and a read address equals iwriteRegWire, that port SHALL return wb_data in the same cycle (write-before-read).
REQ-021 rs and rt bypass SHALL be independent; both SHALL bypass when both match.
REQ-022 With enable=0, no register and no counter SHALL change, and bypass SHALL NOT apply.
REQ-023 retire_count SHALL increment by 1 on an edge with enable=1 and iInstr != 32'h0, regardless of iRegWrite.
REQ-024 retire_count SHALL wrap from 32'hFFFFFFFF to 0 without a flag.
REQ-025 X on iouputData SHALL not propagate to the array when iMemToReg=0.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear every register, including register 0, and retire_count to 0.
REQ-027 While reset_n=0, no write or count SHALL occur; rs_data/rt_data SHALL read 0, except that bypass per REQ-020 still applies.
REQ-028 The first edge after reset_n rises SHALL behave per REQ-017/REQ-023; no extra warm-up cycle.
REQ-029 Reset asserted mid-write SHALL win; the written register SHALL read 0 afterward.

Structure
REQ-030 WORD_W, REG_AW and the bubble constant NOP_INSTR=32'h0 SHALL live in the shared pipeline package.
REQ-031 The storage array with one write port and two raw read ports SHALL be sub-module wb_regfile_array.
REQ-032 The write-data mux, bypass, and retire counter SHALL be in wb_regfile.

Verification
REQ-033 Write then read: iRegWrite=1, iMemToReg=0, iALUResult=32'h12345678, dest=5; next cycle rs_addr=5 -> rs_data=32'h12345678.
REQ-034 Load path and bypass: iMemToReg=1, iouputData=32'hDEADBEEF, dest=7, rs_addr=rt_addr=7 in the same cycle -> rs_data=rt_data=32'hDEADBEEF before the edge.
REQ-035 Register 0 write: dest=0, data=32'hFFFFFFFF -> wb_we=0; rs_addr=0 -> rs_data=0 in that cycle and after.
REQ-036 Enable low: enable=0, dest=3, data=32'hA5A5A5A5 -> r3 unchanged at 0, retire_count unchanged.
REQ-037 Counter: 3 non-zero iInstr, then 1 bubble, then 1 non-zero -> retire_count=4; with the counter forced to 32'hFFFFFFFF plus 1 retire -> 0.
REQ-038 Async reset: write r9=32'h1, pulse reset_n low between edges -> r9 and retire_count read 0 immediately.
